step_sequencer: RTL



---
 rtl/step_seq_pkg.sv | 13 +
 rtl/button_debounce.sv | 79 +++++++
 rtl/step_sequencer.sv | 80 ++++++++
 3 files changed

// File: rtl/step_seq_pkg.sv
// Shared types and constants for the step sequencer and its button debouncers.
package step_seq_pkg;

   localparam int STEP_W = 3;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } deb_state_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus press/release debounce FSM; press pulses once per accepted press.
//
// state        | meaning
// IDLE         | button released and stable, waiting for a press
// PRESS_WAIT   | press seen, counting stable-high cycles
// HELD         | press accepted, waiting for release
// RELEASE_WAIT | release seen, counting stable-low cycles
module button_debounce
   import step_seq_pkg::*;
#(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press
);

   localparam int CW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic       sync_q1;
   logic       sync_q2;
   deb_state_t state;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sync_q2) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!sync_q2)
                  state <= IDLE;
               else if (cnt == CNT_LAST)
                  state <= HELD;
               else
                  cnt <= cnt + CW'(1);
            end
            HELD: begin
               if (!sync_q2) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (sync_q2)
                  state <= HELD;
               else if (cnt == CNT_LAST)
                  state <= IDLE;
               else
                  cnt <= cnt + CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Decoded from flops only: high in the cycle whose closing edge enters HELD.
   assign press = (state == PRESS_WAIT) && sync_q2 && (cnt == CNT_LAST);

endmodule

// File: rtl/step_sequencer.sv
// Prescaled 3-bit up/down step counter with debounced gray-mode toggle.
// Optional STEP_SEQ_SINGLE_STEP_EN adds a STEP_BTN input for manual stepping while paused.
module step_sequencer
   import step_seq_pkg::*;
#(
   parameter int TICK_DIV   = 50000000,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              EN,
   input  logic              DIR,
   input  logic              MODE_BTN,
`ifdef STEP_SEQ_SINGLE_STEP_EN
   input  logic              STEP_BTN,
`endif
   output logic [STEP_W-1:0] A,
   output logic              USE_GRAY,
   output logic              TICK
);

   localparam int PRE_W = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0]  pre_cnt;
   logic [STEP_W-1:0] next_a;
   logic              mode_press;
   logic              manual_step;

   button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (MODE_BTN),
      .press (mode_press)
   );

`ifdef STEP_SEQ_SINGLE_STEP_EN
   logic step_press;

   button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (STEP_BTN),
      .press (step_press)
   );

   // Gating on the live EN also drops a press that lands on the cycle EN rises.
   assign manual_step = step_press && !EN;
`else
   assign manual_step = 1'b0;
`endif

   assign next_a = DIR ? (A + STEP_W'(1)) : (A - STEP_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt  <= '0;
         A        <= '0;
         USE_GRAY <= 1'b0;
         TICK     <= 1'b0;
      end else begin
         TICK <= 1'b0;
         if (mode_press)
            USE_GRAY <= ~USE_GRAY;
         if (EN) begin
            if (pre_cnt == PRE_LAST) begin
               pre_cnt <= '0;
               A       <= next_a;
               TICK    <= 1'b1;
            end else begin
               pre_cnt <= pre_cnt + PRE_W'(1);
            end
         end else if (manual_step) begin
            A    <= next_a;
            TICK <= 1'b1;
         end
      end
   end

endmodule
